// File: rtl/output_unit.sv
// Frame de-serialiser: buffers one 64-point frame (8 row beats x 8 lanes) and streams it out one complex sample per handshake.
// Latency: first dout_valid in the cycle after the 8th accepted row beat; 72 cycles/frame at full throughput.
// Backpressure: in_ready low while sending (beats offered then are dropped and flag overflow); dout_valid holds until handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   din_valid, dinre, dinim  row beat input, lane k at bits [DW*k +: DW]
//   in_ready                 high when a row beat can be accepted
//   dout_valid, dout_ready   output sample handshake
//   doutre, doutim           current output sample (0 when not valid)
//   dout_index, dout_last    output position n and end-of-frame marker
//   overflow                 sticky flag: row beat offered while sending
module output_unit #(
  parameter int DW     = 10,
  parameter bit BITREV = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  input  logic [8*DW-1:0] dinre,
  input  logic [8*DW-1:0] dinim,
  output logic            in_ready,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [DW-1:0]   doutre,
  output logic [DW-1:0]   doutim,
  output logic [5:0]      dout_index,
  output logic            dout_last,
  output logic            overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]      r_state;
  logic [2:0]      r_row;
  logic [5:0]      r_idx;
  logic            r_ovf;
  logic [2*DW-1:0] r_buf [0:63];

  logic            w_sending;
  logic            w_accept;
  logic [2:0]      w_wr_row;
  logic [5:0]      w_addr;
  logic [2*DW-1:0] w_rd;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    logic [5:0] r;
    for (int b = 0; b < 6; b++) begin
      r[b] = a[5-b];
    end
    return r;
  endfunction

  assign w_sending = (r_state == S_SEND);
  assign w_accept  = din_valid & ~w_sending;
  // In IDLE the counter is already 0, but selecting row 0 explicitly keeps the
  // first beat correct even if the counter were ever left non-zero.
  assign w_wr_row  = (r_state == S_IDLE) ? 3'd0 : r_row;
  assign w_addr    = BITREV ? bitrev6(r_idx) : r_idx;
  assign w_rd      = r_buf[w_addr];

  // Control FSM: row counter during load, index counter during send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= 3'd0;
      r_idx   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (din_valid) begin
            r_row   <= 3'd1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (din_valid) begin
            if (r_row == 3'd7) begin
              r_row   <= 3'd0;
              r_state <= S_SEND;
            end else begin
              r_row <= r_row + 3'd1;
            end
          end
        end
        S_SEND: begin
          if (dout_ready) begin
            if (r_idx == 6'd63) begin
              r_idx   <= 6'd0;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_row   <= 3'd0;
          r_idx   <= 6'd0;
        end
      endcase
    end
  end

  // Sticky overflow: any beat offered while sending is dropped and recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (din_valid && w_sending) begin
      r_ovf <= 1'b1;
    end
  end

  // Frame buffer: entry e = 8*k + r holds lane k of row beat r, stored {im, re}.
  // Each entry is written only when its row is the one being loaded.
  for (genvar e = 0; e < 64; e++) begin : g_buf
    localparam int LANE = e / 8;
    localparam logic [2:0] ROW = 3'(e % 8);
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_buf[e] <= '0;
      end else if (w_accept && (w_wr_row == ROW)) begin
        r_buf[e] <= {dinim[DW*LANE +: DW], dinre[DW*LANE +: DW]};
      end
    end
  end

  assign in_ready   = ~w_sending;
  assign dout_valid = w_sending;
  // Data is gated so the bus reads 0 outside a frame rather than stale buffer contents.
  assign doutre     = w_sending ? w_rd[DW-1:0]    : '0;
  assign doutim     = w_sending ? w_rd[2*DW-1:DW] : '0;
  assign dout_index = r_idx;
  assign dout_last  = w_sending & (r_idx == 6'd63);
  assign overflow   = r_ovf;

endmodule
